// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment constants for the 7-segment display slice
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } arb_state_t;

   // Segment encoding is xGFEDCBA, 1 = lit.
   localparam logic [7:0] LETTER_BLANK = 8'h00;
   localparam logic [7:0] LETTER_H     = 8'h76;
   localparam logic [7:0] LETTER_E     = 8'h79;
   localparam logic [7:0] LETTER_L     = 8'h38;
   localparam logic [7:0] LETTER_O     = 8'h3F;
   localparam logic [7:0] LETTER_P     = 8'h73;
   localparam logic [7:0] SEG_BLANK    = LETTER_BLANK;

endpackage

// File: rtl/seg7_rr_pick.sv
// rtl/seg7_rr_pick.sv - combinational round-robin picker: first request at or after pointer
module seg7_rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] pointer,
   output logic [NREQ-1:0]  onehot,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   // Scan from farthest to nearest so the nearest requester at/after pointer wins.
   always_comb begin
      onehot = '0;
      index  = '0;
      valid  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int j;
         j = (int'(pointer) + k) % NREQ;
         if (req[j]) begin
            onehot = NREQ'(1) << j;
            index  = IDX_W'(j);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - round-robin time-sharing of one 7-segment output with dwell and blank gaps
module seg7_display_arbiter
   import seg7_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int TICK_W     = 22,
   parameter int HOLD_TICKS = 4,
   parameter int GAP_TICKS  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] seg_in,
   output logic [NREQ-1:0]   grant,
   output logic [7:0]        seg_out,
   output logic              tick
);

   localparam int IDX_W  = $clog2(NREQ);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int GAP_W  = $clog2(GAP_TICKS + 1);

   logic [TICK_W-1:0] presc;
   arb_state_t        state;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  pointer;
   logic [HOLD_W-1:0] hold_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic [NREQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]  pick_index;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_next;
   logic [7:0]        owner_seg;
   logic              owner_req;
   logic              other_pending;

   seg7_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .pointer (pointer),
      .onehot  (pick_onehot),
      .index   (pick_index),
      .valid   (pick_valid)
   );

   // Free-running; grants never restart it, so tick phase is independent of ownership.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= presc + 1'b1;
         tick  <= &presc;
      end
   end

   always_comb begin
      owner_seg = SEG_BLANK;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IDX_W'(i)) owner_seg = seg_in[i*8 +: 8];
      end
   end

   assign pick_next     = (pick_index == IDX_W'(NREQ - 1)) ? '0 : pick_index + 1'b1;
   assign owner_req     = |(req & grant);
   assign other_pending = |(req & ~grant);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         seg_out  <= SEG_BLANK;
         owner    <= '0;
         pointer  <= '0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               grant   <= '0;
               seg_out <= SEG_BLANK;
               if (pick_valid) begin
                  grant    <= pick_onehot;
                  owner    <= pick_index;
                  pointer  <= pick_next;
                  hold_cnt <= HOLD_W'(HOLD_TICKS);
                  state    <= SHOW;
               end
            end
            SHOW: begin
               seg_out <= owner_seg;
               if (!owner_req || (hold_cnt == '0 && other_pending)) begin
                  state   <= GAP;
                  grant   <= '0;
                  seg_out <= SEG_BLANK;
                  gap_cnt <= GAP_W'(GAP_TICKS);
               end else if (hold_cnt == '0) begin
                  hold_cnt <= HOLD_W'(HOLD_TICKS);
               end else if (tick) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            GAP: begin
               grant   <= '0;
               seg_out <= SEG_BLANK;
               // The tick of the very first GAP cycle already counts toward the gap.
               if (tick) begin
                  if (gap_cnt <= GAP_W'(1)) begin
                     gap_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb/tb_seg7_display_arbiter.sv - directed, table-driven bench for seg7_display_arbiter
module tb_seg7_display_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] seg_in;
   logic [3:0]  grant;
   logic [7:0]  seg_out;
   logic        tick;

   int checks = 0;
   int fails  = 0;
   int show_ticks;
   int gap_ticks;

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_grant;
      logic [7:0] exp_seg;
   } vec_t;

   vec_t vecs[8];

   seg7_display_arbiter #(
      .NREQ       (4),
      .TICK_W     (2),
      .HOLD_TICKS (2),
      .GAP_TICKS  (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .seg_in  (seg_in),
      .grant   (grant),
      .seg_out (seg_out),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] r);
      reset = 1'b1;
      req   = 4'b0000;
      step();
      step();
      check("reset_grant", int'(grant), 0);
      check("reset_seg_out", int'(seg_out), 0);
      check("reset_tick", int'(tick), 0);
      reset = 1'b0;
      req   = r;
   endtask

   function automatic int idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return -1;
   endfunction

   // Runs out the current window and gap, returns the next owner index.
   task automatic next_grant(output int owner);
      int n;
      n = 0;
      show_ticks = 0;
      gap_ticks  = 0;
      while (grant != 4'b0000 && n < 300) begin
         if (tick) show_ticks++;
         step();
         n++;
      end
      while (grant == 4'b0000 && n < 300) begin
         if (tick) gap_ticks++;
         step();
         n++;
      end
      if (n >= 300) begin
         check("grant_timeout", n, 0);
         owner = -1;
      end else begin
         owner = idx_of(grant);
      end
   endtask

   always @(negedge clk) begin
      checks++;
      if (!$onehot0(grant)) begin
         fails++;
         $display("FAIL grant_onehot: got %b at %0t", grant, $time);
      end
      checks++;
      if (grant == 4'b0000 && seg_out != 8'h00) begin
         fails++;
         $display("FAIL blank_when_idle: seg_out 0x%0h, expected 0x00 at %0t", seg_out, $time);
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int own;
      int first;
      int prev;
      bit held;
      int exp_order[5];

      reset  = 1'b1;
      req    = 4'b0000;
      seg_in = {8'h3F, 8'h38, 8'h79, 8'h76};

      vecs[0] = '{4'b0001, 4'b0001, 8'h76};
      vecs[1] = '{4'b0101, 4'b0001, 8'h76};
      vecs[2] = '{4'b0100, 4'b0100, 8'h38};
      vecs[3] = '{4'b1000, 4'b1000, 8'h3F};
      vecs[4] = '{4'b1110, 4'b0010, 8'h79};
      vecs[5] = '{4'b0110, 4'b0010, 8'h79};
      vecs[6] = '{4'b1100, 4'b0100, 8'h38};
      vecs[7] = '{4'b1010, 4'b0010, 8'h79};

      // Idle after reset, tick every 4 cycles
      do_reset(4'b0000);
      first = -1;
      prev  = -1;
      for (int n = 1; n <= 16; n++) begin
         step();
         if (tick) begin
            if (first < 0) first = n;
            else check("tick_period", n - prev, 4);
            prev = n;
         end
      end
      check("first_tick", first, 4);
      check("idle_grant", int'(grant), 0);
      check("idle_seg_out", int'(seg_out), 0);

      // First grant from a fresh pointer, then the owner's pattern one cycle later
      foreach (vecs[v]) begin
         do_reset(vecs[v].req);
         step();
         check($sformatf("vec%0d_grant", v), int'(grant), int'(vecs[v].exp_grant));
         step();
         check($sformatf("vec%0d_seg", v), int'(seg_out), int'(vecs[v].exp_seg));
      end

      // Single requester keeps the display with no gap; pattern changes pass through
      do_reset(4'b0001);
      step();
      check("solo_grant", int'(grant), 1);
      step();
      check("solo_seg", int'(seg_out), 8'h76);
      held = 1'b1;
      for (int n = 0; n < 40; n++) begin
         step();
         if (grant != 4'b0001 || seg_out != 8'h76) held = 1'b0;
      end
      check("solo_held", int'(held), 1);
      seg_in[7:0] = 8'h73;
      step();
      check("solo_passthru", int'(seg_out), 8'h73);
      seg_in[7:0] = 8'h76;

      // Two requesters alternate with 2-tick windows and a 1-tick blank gap
      do_reset(4'b0101);
      next_grant(own);
      check("alt_first", own, 0);
      for (int k = 0; k < 3; k++) begin
         next_grant(own);
         check($sformatf("alt_owner%0d", k), own, (k % 2 == 0) ? 2 : 0);
         check($sformatf("alt_show_ticks%0d", k), show_ticks, 2);
         check($sformatf("alt_gap_ticks%0d", k), gap_ticks, 1);
      end

      // All requesting: round-robin order 0,1,2,3,0
      exp_order = '{0, 1, 2, 3, 0};
      do_reset(4'b1111);
      for (int k = 0; k < 5; k++) begin
         next_grant(own);
         check($sformatf("rr_owner%0d", k), own, exp_order[k]);
         if (k > 0) begin
            check($sformatf("rr_show_ticks%0d", k), show_ticks, 2);
            check($sformatf("rr_gap_ticks%0d", k), gap_ticks, 1);
         end
      end

      // Owner drops right after grant: gap next cycle, then pending requester 2
      do_reset(4'b0110);
      step();
      check("drop_grant", int'(grant), 4'b0010);
      req = 4'b0100;
      step();
      check("drop_gap_grant", int'(grant), 0);
      check("drop_gap_seg", int'(seg_out), 0);
      next_grant(own);
      check("drop_next_owner", own, 2);
      check("drop_gap_ticks", gap_ticks, 1);

      // Reset mid-SHOW of owner 3 drops it at once; pointer restarts at 0
      do_reset(4'b1111);
      for (int k = 0; k < 4; k++) next_grant(own);
      check("mid_owner", own, 3);
      step();
      step();
      check("mid_still_owner", int'(grant), 4'b1000);
      reset = 1'b1;
      step();
      check("mid_reset_grant", int'(grant), 0);
      check("mid_reset_seg", int'(seg_out), 0);
      reset = 1'b0;
      req   = 4'b1111;
      step();
      check("post_reset_grant", int'(grant), 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
